// File: rtl/spi_flash_reader_if.sv
// Bundle of the request, read-data and SPI byte-shifter signals seen by spi_flash_reader.
// The master modport is the sequencer's view; slave is the environment's view.
interface spi_flash_reader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic        done;
    logic        mem_cs_n;
    logic        spi_ready;
    logic [7:0]  spi_tx_data;
    logic        spi_data_valid;
    logic [7:0]  spi_rx_data;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, rd_ready, spi_ready, spi_rx_data,
        output cmd_ready, rd_data, rd_valid, busy, done, mem_cs_n, spi_tx_data, spi_data_valid
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, rd_ready, spi_ready, spi_rx_data,
        input  cmd_ready, rd_data, rd_valid, busy, done, mem_cs_n, spi_tx_data, spi_data_valid
    );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI flash read-command sequencer: drives chip-select, sends opcode + 24-bit address,
// clocks dummy bytes and hands each received data byte out on a single-entry valid/ready slot.
module spi_flash_reader #(
    parameter logic [7:0]  READ_OPCODE = 8'h03,
    parameter int unsigned CS_SETUP    = 2,
    parameter int unsigned CS_HOLD     = 2
) (
    input logic               clock,
    input logic               reset,
    spi_flash_reader_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StIssue, StLaunch, StWait, StCapture, StHold
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] rem_q, rem_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cs_n_q, cs_n_d;
    logic [7:0]  tx_q, tx_d;
    logic        dv_q, dv_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            idx_q      <= 3'd0;
            rem_q      <= 16'd0;
            addr_q     <= 24'd0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_q       <= 8'h00;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_n_q     <= cs_n_d;
            tx_q       <= tx_d;
            dv_q       <= dv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q && !bus.rd_ready;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_n_d     = cs_n_q;
        tx_d       = tx_q;
        dv_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    rem_d  = bus.cmd_len;
                    idx_d  = 3'd0;
                    if (bus.cmd_len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        cs_n_d  = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = 8'(CS_SETUP);
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_d == 8'd0) state_d = StIssue;
            end
            StIssue: begin
                if (rem_q == 16'd0) begin
                    cnt_d   = 8'(CS_HOLD);
                    state_d = StHold;
                end else if (idx_q == 3'd4 && rd_valid_q && !bus.rd_ready) begin
                    // Data byte would land on an occupied slot; wait for the consumer.
                    state_d = StIssue;
                end else if (bus.spi_ready) begin
                    dv_d    = 1'b1;
                    state_d = StLaunch;
                    case (idx_q)
                        3'd0:    tx_d = READ_OPCODE;
                        3'd1:    tx_d = addr_q[23:16];
                        3'd2:    tx_d = addr_q[15:8];
                        3'd3:    tx_d = addr_q[7:0];
                        default: tx_d = 8'h00;
                    endcase
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                if (bus.spi_ready) state_d = StCapture;
            end
            StCapture: begin
                if (idx_q == 3'd4) begin
                    rd_data_d  = bus.spi_rx_data;
                    rd_valid_d = 1'b1;
                    rem_d      = rem_q - 16'd1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
                state_d = StIssue;
            end
            StHold: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_d == 8'd0) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.cmd_ready      = (state_q == StIdle);
    assign bus.rd_data        = rd_data_q;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mem_cs_n       = cs_n_q;
    assign bus.spi_tx_data    = tx_q;
    assign bus.spi_data_valid = dv_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader with a behavioural SPI byte-shifter model.
module tb_spi_flash_reader;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spi_flash_reader_if bus ();

    spi_flash_reader #(
        .READ_OPCODE(8'h03),
        .CS_SETUP   (2),
        .CS_HOLD    (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rx_src[$];
    int         exp_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Shifter model: busy for 3 cycles per byte, rx updates as ready returns.
    logic       sh_busy;
    logic [3:0] sh_cnt;
    logic [7:0] sh_rx, sh_pend;
    int         lc;
    logic       hold_low = 1'b0;

    assign bus.spi_ready   = !sh_busy && !bus.spi_data_valid && !hold_low;
    assign bus.spi_rx_data = sh_rx;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh_busy <= 1'b0;
            sh_cnt  <= 4'd0;
            sh_rx   <= 8'h00;
            sh_pend <= 8'h00;
            lc      <= 0;
        end else begin
            if (bus.mem_cs_n) lc <= 0;
            if (bus.spi_data_valid) begin
                sh_busy <= 1'b1;
                sh_cnt  <= 4'd3;
                lc      <= lc + 1;
                if (lc >= 4 && rx_src.size() > 0) sh_pend <= rx_src.pop_front();
                else sh_pend <= 8'hC3;
            end else if (sh_busy) begin
                if (sh_cnt == 4'd1) begin
                    sh_busy <= 1'b0;
                    sh_rx   <= sh_pend;
                end
                sh_cnt <= sh_cnt - 4'd1;
            end
        end
    end

    // Monitor: compares launches, delivered bytes and done pulses against the queues.
    logic [7:0] mon_e;
    always @(negedge clock) begin
        if (reset) begin
            if (bus.spi_data_valid) begin
                chk("launch_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) begin
                    mon_e = exp_tx.pop_front();
                    chk("spi_tx_data", 32'(bus.spi_tx_data), 32'(mon_e));
                end
                chk("cs_low_on_launch", 32'(bus.mem_cs_n), 32'd0);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) begin
                    mon_e = exp_rd.pop_front();
                    chk("rd_data", 32'(bus.rd_data), 32'(mon_e));
                end
            end
            if (bus.done) begin
                chk("done_expected", 32'(exp_done > 0), 32'd1);
                if (exp_done > 0) exp_done--;
                chk("cs_high_at_done", 32'(bus.mem_cs_n), 32'd1);
                chk("busy_low_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic add_data(input logic [7:0] b);
        rx_src.push_back(b);
        exp_rd.push_back(b);
    endtask

    task automatic issue(input logic [23:0] a, input logic [15:0] l);
        int k = 0;
        while (!bus.cmd_ready && k < 500) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("cmd_ready_before_issue", 32'(bus.cmd_ready), 32'd1);
        if (l != 16'd0) begin
            exp_tx.push_back(8'h03);
            exp_tx.push_back(a[23:16]);
            exp_tx.push_back(a[15:8]);
            exp_tx.push_back(a[7:0]);
            for (int i = 0; i < int'(l); i++) exp_tx.push_back(8'h00);
        end
        exp_done++;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int k = 0;
        while (!(exp_tx.size() == 0 && exp_rd.size() == 0 && exp_done == 0 && !bus.busy)
               && k < 3000) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk(name, 32'(exp_tx.size() == 0 && exp_rd.size() == 0 && exp_done == 0 && !bus.busy),
            32'd1);
    endtask

    task automatic wait_rd_valid(input string name);
        int k = 0;
        while (!bus.rd_valid && k < 500) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk(name, 32'(bus.rd_valid), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h00);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_cs_n", 32'(bus.mem_cs_n), 32'd1);
        chk("rst_spi_tx_data", 32'(bus.spi_tx_data), 32'h00);
        chk("rst_spi_data_valid", 32'(bus.spi_data_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, expected below 2000000",
                 $time);
        $fatal(1);
    end

    initial begin
        int nl;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 24'd0;
        bus.cmd_len   = 16'd0;
        bus.rd_ready  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals();
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Basic two-byte read.
        add_data(8'hA5);
        add_data(8'h5A);
        issue(24'h123456, 16'd2);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("cs_low_after_accept", 32'(bus.mem_cs_n), 32'd0);
        wait_quiet("t1_complete");

        // Zero-length read: done the cycle after accept, chip-select untouched.
        issue(24'h000000, 16'd0);
        chk("len0_done", 32'(bus.done), 32'd1);
        chk("len0_cs_high", 32'(bus.mem_cs_n), 32'd1);
        chk("len0_busy_low", 32'(bus.busy), 32'd0);
        repeat (5) @(posedge clock);
        #1;
        chk("len0_cs_still_high", 32'(bus.mem_cs_n), 32'd1);
        wait_quiet("t2_complete");

        // Back-pressure: consumer stalls after first data byte.
        bus.rd_ready = 1'b0;
        add_data(8'h11);
        add_data(8'h22);
        add_data(8'h33);
        issue(24'hFEDCBA, 16'd3);
        wait_rd_valid("t3_first_rd_valid");
        nl = 0;
        repeat (100) begin
            @(posedge clock);
            #1;
            if (bus.spi_data_valid) nl++;
        end
        chk("t3_no_launch_while_full", 32'(nl), 32'd0);
        chk("t3_rd_valid_held", 32'(bus.rd_valid), 32'd1);
        chk("t3_rd_data_held", 32'(bus.rd_data), 32'h11);
        bus.rd_ready = 1'b1;
        wait_quiet("t3_complete");

        // Request while busy is ignored; a re-issue after done runs normally.
        add_data(8'h9C);
        issue(24'h000010, 16'd1);
        repeat (3) @(posedge clock);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 24'hBAD000;
        bus.cmd_len   = 16'd4;
        chk("t4_cmd_ready_low_busy", 32'(bus.cmd_ready), 32'd0);
        chk("t4_busy", 32'(bus.busy), 32'd1);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        wait_quiet("t4_first_complete");
        add_data(8'h4E);
        issue(24'h0A0B0C, 16'd1);
        wait_quiet("t4_reissue_complete");

        // Asynchronous reset in the data phase.
        bus.rd_ready = 1'b0;
        add_data(8'h61);
        add_data(8'h62);
        issue(24'h0F0F0F, 16'd2);
        wait_rd_valid("t5_rd_valid_before_reset");
        #1;
        reset = 1'b0;
        #1;
        chk_reset_vals();
        exp_tx.delete();
        exp_rd.delete();
        rx_src.delete();
        exp_done = 0;
        bus.rd_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        add_data(8'h3C);
        issue(24'hABCDEF, 16'd1);
        wait_quiet("t5_after_reset_complete");

        // Shifter not ready through the end of SETUP: hold in ISSUE, then launch opcode.
        add_data(8'h77);
        issue(24'h000100, 16'd1);
        hold_low = 1'b1;
        nl = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (bus.spi_data_valid) nl++;
        end
        chk("t6_no_launch_while_not_ready", 32'(nl), 32'd0);
        chk("t6_cs_low", 32'(bus.mem_cs_n), 32'd0);
        hold_low = 1'b0;
        @(posedge clock);
        #1;
        chk("t6_launch_next_cycle", 32'(bus.spi_data_valid), 32'd1);
        chk("t6_opcode", 32'(bus.spi_tx_data), 32'h03);
        wait_quiet("t6_complete");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
